ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_if.sv | 30 +++
 rtl/ifetch_unit.sv | 147 ++++++++++++++
 tb/tb_ifetch_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_if
// Description : Instruction-memory, decode-side and redirect signals of the
//               fetch unit, grouped with master (fetch unit) / slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, stall, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch with one outstanding request, output
//               register plus one-entry skid buffer, and branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire      clk,
    input  wire      rst,
    ifetch_if.master bus
);

    localparam logic [1:0] c_RUN  = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        w_ack_take;
    logic        w_to_out;

    assign w_ack_take = (state_q == c_WAIT) && bus.imem_ack && !bus.redirect_valid;
    assign w_to_out   = !inst_valid_q || !bus.stall;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_RUN: begin
                if (bus.redirect_valid) begin
                    state_d = c_RUN;
                end else if (!skid_valid_q || !bus.stall) begin
                    state_d = c_WAIT;
                end
            end
            c_WAIT: begin
                if (bus.redirect_valid) begin
                    state_d = c_DROP;
                end else if (bus.imem_ack) begin
                    state_d = w_to_out ? c_WAIT : c_RUN;
                end
            end
            c_DROP: begin
                if (bus.imem_ack) begin
                    state_d = c_RUN;
                end
            end
            default: state_d = c_RUN;
        endcase
    end

    // Outputs; DROP keeps presenting the abandoned address until its ack
    always_comb begin
        bus.imem_req   = (state_q != c_RUN);
        bus.imem_addr  = (state_q == c_DROP) ? drop_addr_q : pc_q;
        bus.inst_valid = inst_valid_q;
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        if (bus.redirect_valid) begin
            pc_d         = bus.redirect_pc & 32'hFFFF_FFFC;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            skid_valid_d = 1'b0;
            if (state_q == c_WAIT) begin
                drop_addr_d = pc_q;
            end
        end else if (w_ack_take) begin
            pc_d = pc_q + 32'd4;
            if (w_to_out) begin
                inst_valid_d = 1'b1;
                inst_d       = bus.imem_rdata;
                inst_pc_d    = pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_inst_d  = bus.imem_rdata;
                skid_pc_d    = pc_q;
            end
        end else if (!bus.stall) begin
            if (skid_valid_q) begin
                inst_valid_d = 1'b1;
                inst_d       = skid_inst_q;
                inst_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                inst_valid_d = 1'b0;
                inst_d       = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drop_addr_q  <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed vector bench for ifetch_unit (cycle table plus an
//               asynchronous-reset sequence).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] c_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_DEAD = 32'hDEAD_BEEF;
    localparam int          c_NVEC = 28;

    typedef struct {
        logic        st;
        logic        ack;
        logic [31:0] rd;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [c_NVEC];

    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (c_NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic st, input logic ack, input logic [31:0] rd,
                                input logic rv, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_inst,
                                input logic [31:0] e_ipc);
        vec_t v;
        v.st = st; v.ack = ack; v.rd = rd; v.rv = rv; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_iv, input logic [31:0] e_inst,
                           input logic [31:0] e_ipc);
        chk("imem_req", idx, {31'd0, bus.imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", idx, bus.imem_addr, e_addr);
        chk("inst_valid", idx, {31'd0, bus.inst_valid}, {31'd0, e_iv});
        chk("inst", idx, bus.inst, e_inst);
        if (e_iv) chk("inst_pc", idx, bus.inst_pc, e_ipc);
    endtask

    task automatic drive(input logic st, input logic ack, input logic [31:0] rd,
                         input logic rv, input logic [31:0] rpc);
        bus.stall          = st;
        bus.imem_ack       = ack;
        bus.imem_rdata     = rd;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    initial begin
        // stall ack rdata rv rpc | req addr iv inst ipc
        vecs[0]  = mk(0, 0, 0,        0, 0,            1, 32'h0,        0, c_NOP,   0);
        vecs[1]  = mk(0, 1, 32'hA0,   0, 0,            1, 32'h4,        1, 32'hA0,  32'h0);
        vecs[2]  = mk(0, 1, 32'hA4,   0, 0,            1, 32'h8,        1, 32'hA4,  32'h4);
        vecs[3]  = mk(0, 1, 32'hA8,   0, 0,            1, 32'hC,        1, 32'hA8,  32'h8);
        vecs[4]  = mk(0, 0, 0,        0, 0,            1, 32'hC,        0, c_NOP,   0);
        vecs[5]  = mk(0, 1, 32'hAC,   0, 0,            1, 32'h10,       1, 32'hAC,  32'hC);
        vecs[6]  = mk(1, 1, 32'hB0,   0, 0,            0, 32'h14,       1, 32'hAC,  32'hC);
        vecs[7]  = mk(1, 1, c_DEAD,   0, 0,            0, 32'h14,       1, 32'hAC,  32'hC);
        vecs[8]  = mk(0, 0, 0,        0, 0,            1, 32'h14,       1, 32'hB0,  32'h10);
        vecs[9]  = mk(0, 1, 32'hB4,   0, 0,            1, 32'h18,       1, 32'hB4,  32'h14);
        vecs[10] = mk(0, 0, 0,        1, 32'h103,      1, 32'h18,       0, c_NOP,   0);
        vecs[11] = mk(0, 0, 0,        0, 0,            1, 32'h18,       0, c_NOP,   0);
        vecs[12] = mk(0, 1, c_DEAD,   0, 0,            0, 32'h100,      0, c_NOP,   0);
        vecs[13] = mk(0, 0, 0,        0, 0,            1, 32'h100,      0, c_NOP,   0);
        vecs[14] = mk(0, 1, 32'hC0,   0, 0,            1, 32'h104,      1, 32'hC0,  32'h100);
        vecs[15] = mk(1, 1, 32'hC4,   0, 0,            0, 32'h108,      1, 32'hC0,  32'h100);
        vecs[16] = mk(1, 0, 0,        1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, c_NOP, 0);
        vecs[17] = mk(0, 0, 0,        0, 0,            1, 32'hFFFF_FFFC, 0, c_NOP,   0);
        vecs[18] = mk(0, 1, 32'hD0,   0, 0,            1, 32'h0,        1, 32'hD0,  32'hFFFF_FFFC);
        vecs[19] = mk(0, 0, 0,        1, 32'h200,      1, 32'h0,        0, c_NOP,   0);
        vecs[20] = mk(0, 0, 0,        1, 32'h300,      1, 32'h0,        0, c_NOP,   0);
        vecs[21] = mk(0, 1, c_DEAD,   1, 32'h404,      0, 32'h404,      0, c_NOP,   0);
        vecs[22] = mk(0, 0, 0,        0, 0,            1, 32'h404,      0, c_NOP,   0);
        vecs[23] = mk(0, 1, c_DEAD,   1, 32'h500,      1, 32'h404,      0, c_NOP,   0);
        vecs[24] = mk(0, 1, c_DEAD,   0, 0,            0, 32'h500,      0, c_NOP,   0);
        vecs[25] = mk(0, 0, 0,        0, 0,            1, 32'h500,      0, c_NOP,   0);
        vecs[26] = mk(1, 1, 32'hE0,   0, 0,            1, 32'h504,      1, 32'hE0,  32'h500);
        vecs[27] = mk(1, 0, 0,        0, 0,            1, 32'h504,      1, 32'hE0,  32'h500);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        chk_out(-1, 0, 32'h0, 0, c_NOP, 32'h0);
        chk("inst_pc_reset", -1, bus.inst_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].st, vecs[i].ack, vecs[i].rd, vecs[i].rv, vecs[i].rpc);
            @(posedge clk);
            #1;
            chk_out(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                    vecs[i].e_inst, vecs[i].e_ipc);
        end

        // Asynchronous reset while a request is outstanding, then a stale ack
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_out(100, 0, 32'h0, 0, c_NOP, 32'h0);
        chk("inst_pc_reset", 100, bus.inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, c_DEAD, 0, 0);
        @(posedge clk);
        #1;
        chk_out(101, 1, 32'h0, 0, c_NOP, 32'h0);
        drive(0, 1, 32'hF0, 0, 0);
        @(posedge clk);
        #1;
        chk_out(102, 1, 32'h4, 1, 32'hF0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
